// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared UART definitions for the receiver and transmitter:
//               receiver state encoding and bit-timing helper functions.
//               Contents:
//                 state_t / c_IDLE..c_STOP : 2-bit state encoding
//                 clks_per_bit(freq, baud) : clocks per line bit
//                 half_bit(cpb)            : clocks per half line bit
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE  = 2'd0;
    localparam state_t c_START = 2'd1;
    localparam state_t c_DATA  = 2'd2;
    localparam state_t c_STOP  = 2'd3;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_bit_timer
// Description : Baud tick generator for the UART receiver. Counts clocks and
//               pulses tick at the end of each half or full bit period, then
//               starts the next period from zero.
//               Ports:
//                 clock    : rising-edge clock
//                 reset    : synchronous active-high reset
//                 restart  : hold the counter at zero
//                 halfMode : time a half bit (start-bit centring) not a full one
//                 tick     : period complete (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic halfMode,
    output logic tick
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_HALF  = half_bit(CLKS_PER_BIT);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_last;

    // The half-bit period is one clock shorter: the receiver spends one
    // clock in IDLE recognising the falling edge, and that clock belongs to
    // the half bit, so the start bit is sampled HALF_BIT clocks after the
    // synchronised line first reads 0.
    always_comb begin
        w_last = halfMode ? c_CNT_W'(c_HALF - 2) : c_CNT_W'(CLKS_PER_BIT - 1);
    end

    // ">=" keeps the counter from ever running past the terminal value.
    always_comb begin
        tick = (r_cnt >= w_last);
    end

    always_ff @(posedge clock) begin
        if (reset || restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 2-flop input synchronizer, start-bit
//               glitch rejection and stop-bit framing check.
//               Ports:
//                 clock      : rising-edge clock
//                 reset      : synchronous active-high reset
//                 rx         : asynchronous serial line, idle high
//                 data       : last correctly received byte
//                 dataValid  : one-cycle pulse, new byte on data
//                 frameError : one-cycle pulse, stop bit sampled 0
//                 busy       : receiver not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       dataValid,
    output logic       frameError,
    output logic       busy
);

    localparam int c_CLKS_PER_BIT = clks_per_bit(ClockFrequency, BaudRate);

    generate
        if (c_CLKS_PER_BIT < 4) begin : g_cfg_error
            $error("uart_rx: ClockFrequency/BaudRate must be at least 4");
        end
    endgenerate

    // Synchronizer; r_rxs_prev is the previous synchronized value for
    // falling-edge detection, so a line already low never starts a frame.
    logic r_sync1;
    logic r_rxs;
    logic r_rxs_prev;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;

    logic w_tick;
    logic w_restart;
    logic w_half;
    logic w_shift_en;
    logic w_clr_idx;
    logic w_valid;
    logic w_ferr;

    uart_rx_bit_timer #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_bit_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (w_restart),
        .halfMode (w_half),
        .tick     (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rx;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (!r_rxs && r_rxs_prev) begin
                    w_next_state = c_START;
                end
            end
            c_START: begin
                if (w_tick) begin
                    w_next_state = r_rxs ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) begin
                    w_next_state = c_STOP;
                end
            end
            default: begin
                if (w_tick) begin
                    w_next_state = c_IDLE;
                end
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        w_restart  = (r_state == c_IDLE);
        w_half     = (r_state == c_START);
        w_clr_idx  = (r_state == c_START) && w_tick;
        w_shift_en = (r_state == c_DATA)  && w_tick;
        w_valid    = (r_state == c_STOP)  && w_tick && r_rxs;
        w_ferr     = (r_state == c_STOP)  && w_tick && !r_rxs;
        busy       = (r_state != c_IDLE);
    end

    // Shift register and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            data       <= 8'h00;
            dataValid  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            if (w_clr_idx) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {r_rxs, r_shift[7:1]};
            end
            if (w_valid) begin
                data <= r_shift;
            end
            dataValid  <= w_valid;
            frameError <= w_ferr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at 1 MHz / 9600 baud
//               (104 clocks per bit). Stimulus tasks announce each frame's
//               expected outcome as an event at a computed cycle; a compare
//               process checks the outputs against those events every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CPB = 104;
    // rx driven low in cycle c: two synchronizer clocks, then 52 + 9*104.
    localparam int c_LAT = 2 + 52 + 9 * c_CPB;

    typedef struct {
        int         cyc;
        bit         ok;
        logic [7:0] b;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int         cyc;
    int         n_chk;
    int         n_pass;
    int         n_valid_seen;
    int         n_err_seen;
    int         last_valid_cyc;
    logic [7:0] exp_data;
    ev_t        q[$];
    logic [7:0] seen_bytes[$];

    uart_rx #(
        .ClockFrequency (1000000),
        .BaudRate       (9600)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .rx         (rx),
        .data       (data),
        .dataValid  (data_valid),
        .frameError (frame_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: outputs must match the event schedule every cycle.
    initial begin
        ev_t ev;
        logic exp_v;
        logic exp_e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            exp_v = 1'b0;
            exp_e = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                ev = q.pop_front();
                if (ev.ok) begin
                    exp_v    = 1'b1;
                    exp_data = ev.b;
                end else begin
                    exp_e = 1'b1;
                end
            end
            if (data_valid === 1'b1) begin
                n_valid_seen++;
                last_valid_cyc = cyc;
                seen_bytes.push_back(data);
            end
            if (frame_error === 1'b1) begin
                n_err_seen++;
            end
            chk("dataValid", {31'd0, data_valid}, {31'd0, exp_v});
            chk("frameError", {31'd0, frame_error}, {31'd0, exp_e});
            chk("data", {24'd0, data}, {24'd0, exp_data});
        end
    end

    // Drives one frame starting in the current cycle (called at a negedge).
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_len);
        ev_t ev;
        ev.cyc = cyc + c_LAT;
        ev.ok  = stop_ok;
        ev.b   = b;
        q.push_back(ev);
        rx = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (stop_len) @(negedge clk);
    endtask

    initial begin
        int c0;
        int v0;
        int e0;
        cyc            = 0;
        n_chk          = 0;
        n_pass         = 0;
        n_valid_seen   = 0;
        n_err_seen     = 0;
        last_valid_cyc = -1;
        exp_data       = 8'h00;
        rst            = 1'b1;
        rx             = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'h00);
        rst = 1'b0;

        // Idle line after reset
        repeat (1000) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_data", {24'd0, data}, 32'h00);
        chk("idle_pulses", n_valid_seen + n_err_seen, 32'd0);

        // Single good byte, latency measured from the rx falling edge
        c0 = cyc;
        v0 = n_valid_seen;
        send_frame(8'hA5, 1'b1, c_CPB);
        repeat (20) @(negedge clk);
        chk("a5_data", {24'd0, data}, 32'hA5);
        chk("a5_count", n_valid_seen - v0, 32'd1);
        chk("a5_latency", last_valid_cyc - c0, 32'd990);
        chk("a5_no_err", n_err_seen, 32'd0);

        // Back-to-back: the first stop bit is only as long as needed so the
        // next start edge lands on the first idle cycle after STOP.
        v0 = n_valid_seen;
        send_frame(8'h3C, 1'b1, 52);
        send_frame(8'hC3, 1'b1, c_CPB);
        repeat (20) @(negedge clk);
        chk("b2b_count", n_valid_seen - v0, 32'd2);
        chk("b2b_first", {24'd0, seen_bytes[seen_bytes.size()-2]}, 32'h3C);
        chk("b2b_second", {24'd0, seen_bytes[seen_bytes.size()-1]}, 32'hC3);
        chk("b2b_data", {24'd0, data}, 32'hC3);
        chk("b2b_busy", {31'd0, busy}, 32'd0);

        // Bad stop bit, line then held low
        v0 = n_valid_seen;
        e0 = n_err_seen;
        send_frame(8'h55, 1'b0, c_CPB);
        repeat (300) @(negedge clk);
        chk("ferr_count", n_err_seen - e0, 32'd1);
        chk("ferr_no_valid", n_valid_seen - v0, 32'd0);
        chk("ferr_data_kept", {24'd0, data}, 32'hC3);
        chk("ferr_low_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        repeat (200) @(negedge clk);

        // Start-bit glitch of 20 cycles
        v0 = n_valid_seen;
        e0 = n_err_seen;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
        chk("glitch_pulses", (n_valid_seen - v0) + (n_err_seen - e0), 32'd0);
        repeat (200) @(negedge clk);

        // Reset during data bit 4 of 8'hFF, then a clean 8'h01
        v0 = n_valid_seen;
        e0 = n_err_seen;
        fork
            send_frame(8'hFF, 1'b1, c_CPB);
            begin
                repeat (5 * c_CPB + 30) @(negedge clk);
                rst = 1'b1;
                q.delete();
                exp_data = 8'h00;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (50) @(negedge clk);
        chk("abort_pulses", (n_valid_seen - v0) + (n_err_seen - e0), 32'd0);
        chk("abort_data", {24'd0, data}, 32'h00);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        v0 = n_valid_seen;
        send_frame(8'h01, 1'b1, c_CPB);
        repeat (50) @(negedge clk);
        chk("after_abort_data", {24'd0, data}, 32'h01);
        chk("after_abort_count", n_valid_seen - v0, 32'd1);

        repeat (100) @(negedge clk);
        chk("events_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
